// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-subsystem definitions: arbiter FSM encoding,
// port identifiers, the latched request bundle and the grant picker.
package lc3_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_req_t;

    // Winner among the requesters. Under contention round-robin hands the
    // grant to the port that was not served last; otherwise port 0 wins.
    function automatic logic pick_port(
        input logic r0,
        input logic r1,
        input logic last,
        input logic rr
    );
        if (r0 && r1)
            return rr ? ~last : PORT0;
        return r0 ? PORT0 : PORT1;
    endfunction

endpackage

// File: rtl/lc3_mem_arbiter.sv
// Two-port arbiter in front of a 64K x 16 RAM (combinational read,
// synchronous write). One transaction per 3 cycles: IDLE, SERVE, ACK.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   pN_req/we/addr/wdata     requester N (held until pN_ack)
//   pN_ack                   one-cycle completion pulse
//   rdata                    last read result (held across writes)
//   ram_a/ram_d/ram_we       RAM address, write data, write enable
//   ram_spo                  RAM combinational read data
//   busy, gnt_id             FSM not idle, port currently/last served
module lc3_mem_arbiter
    import lc3_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p0_wdata,
    input  logic [15:0] p1_wdata,
    output logic        p0_ack,
    output logic        p1_ack,
    output logic [15:0] rdata,
    output logic [15:0] ram_a,
    output logic [15:0] ram_d,
    output logic        ram_we,
    input  logic [15:0] ram_spo,
    output logic        busy,
    output logic        gnt_id
);

    logic [1:0] state;
    mem_req_t   lat;
    logic       sel;
    mem_req_t   req_sel;

    always_comb begin
        sel     = pick_port(p0_req, p1_req, gnt_id, RR_EN != 0);
        req_sel = (sel == PORT0) ? {p0_we, p0_addr, p0_wdata}
                                 : {p1_we, p1_addr, p1_wdata};
    end

    // Reset leaves gnt_id at port 1 so port 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            lat    <= '0;
            gnt_id <= PORT1;
            rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (p0_req || p1_req) begin
                        state  <= ST_SERVE;
                        lat    <= req_sel;
                        gnt_id <= sel;
                    end
                end
                ST_SERVE: begin
                    state <= ST_ACK;
                    if (!lat.we)
                        rdata <= ram_spo;
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The latched bundle only changes on a grant, so the RAM address
    // naturally holds its last value while idle.
    assign ram_a  = lat.addr;
    assign ram_d  = lat.wdata;
    assign ram_we = (state == ST_SERVE) && lat.we;
    assign busy   = (state != ST_IDLE);
    assign p0_ack = (state == ST_ACK) && (gnt_id == PORT0);
    assign p1_ack = (state == ST_ACK) && (gnt_id == PORT1);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter: per-port expected queues,
// behavioural RAM model, plus a fixed-priority instance for contention.
module tb_lc3_mem_arbiter;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          drop;
        bit          scr;
        bit          noexp;
        int          lat;
        int          t0;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rq;
    logic [1:0]  we_v;
    logic [15:0] ad [2];
    logic [15:0] wd [2];
    logic [1:0]  ack;
    logic [15:0] rdata, ram_a, ram_d, ram_spo;
    logic        ram_we, busy, gnt_id;

    logic        f_req;
    logic        f_ack0, f_ack1, f_ram_we, f_busy, f_gnt;
    logic [15:0] f_rdata, f_ram_a, f_ram_d, f_spo;

    int          cyc;
    int          mode;
    bit          done;
    bit          tmo;
    txn_t        eq [2][$];

    int          ncmp;
    int          nerr;

    lc3_mem_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(rq[0]), .p1_req(rq[1]),
        .p0_we(we_v[0]), .p1_we(we_v[1]),
        .p0_addr(ad[0]), .p1_addr(ad[1]),
        .p0_wdata(wd[0]), .p1_wdata(wd[1]),
        .p0_ack(ack[0]), .p1_ack(ack[1]),
        .rdata(rdata), .ram_a(ram_a), .ram_d(ram_d),
        .ram_we(ram_we), .ram_spo(ram_spo),
        .busy(busy), .gnt_id(gnt_id)
    );

    lc3_mem_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(f_req), .p1_req(f_req),
        .p0_we(1'b0), .p1_we(1'b0),
        .p0_addr(16'h0010), .p1_addr(16'h0020),
        .p0_wdata(16'h0000), .p1_wdata(16'h0000),
        .p0_ack(f_ack0), .p1_ack(f_ack1),
        .rdata(f_rdata), .ram_a(f_ram_a), .ram_d(f_ram_d),
        .ram_we(f_ram_we), .ram_spo(f_spo),
        .busy(f_busy), .gnt_id(f_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    initial cyc = 0;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0200) ? 16'h2001 : (a ^ 16'hA5C3);
    endfunction

    // RAM block seen by the DUT
    logic [15:0] ram [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = init_val(16'(i));
        forever begin
            @(posedge clk);
            if (ram_we) ram[ram_a] <= ram_d;
        end
    end
    assign ram_spo = ram[ram_a];
    assign f_spo   = init_val(f_ram_a);

    // ---------------- stimulus ----------------
    txn_t    cq [2][$];
    txn_t    cur [2];
    bit      pend [2];

    function automatic txn_t mk(input logic w, input logic [15:0] a,
                                input logic [15:0] d, input bit dr,
                                input bit sc, input int l);
        txn_t t;
        t.we = w; t.addr = a; t.wdata = d; t.drop = dr; t.scr = sc;
        t.noexp = 1'b0; t.lat = l; t.t0 = 0;
        return t;
    endfunction

    task automatic step();
        @(negedge clk);
        f_req = (mode == 1);
        for (int p = 0; p < 2; p++) begin
            if (!rst_n) begin
                pend[p] = 1'b0;
                rq[p]   = 1'b0;
            end else begin
                if (ack[p]) begin
                    pend[p] = 1'b0;
                end else if (pend[p] && busy && gnt_id == 1'(p)) begin
                    if (cur[p].scr) begin
                        we_v[p] = 1'($urandom);
                        ad[p]   = 16'($urandom);
                        wd[p]   = 16'($urandom);
                    end
                    if (cur[p].drop) rq[p] = 1'b0;
                end
                if (!pend[p]) begin
                    if (cq[p].size() > 0 &&
                        (mode != 2 || $urandom_range(0, 2) != 0)) begin
                        cur[p]    = cq[p].pop_front();
                        cur[p].t0 = cyc;
                        rq[p]     = 1'b1;
                        we_v[p]   = cur[p].we;
                        ad[p]     = cur[p].addr;
                        wd[p]     = cur[p].wdata;
                        if (!cur[p].noexp) eq[p].push_back(cur[p]);
                        pend[p]   = 1'b1;
                    end else begin
                        rq[p] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (cq[0].size() == 0 && cq[1].size() == 0 &&
                !pend[0] && !pend[1] && !busy)
                return;
        end
        tmo = 1'b1;
    endtask

    initial begin
        logic [15:0] pool [6];
        txn_t        t;
        bit          seen;
        pool = '{16'h0200, 16'hFE00, 16'h0700, 16'h0300, 16'h1234, 16'hFFFF};
        rst_n = 1'b0; rq = '0; we_v = '0;
        ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        mode = 0; done = 1'b0; tmo = 1'b0; f_req = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        cq[0].push_back(mk(1'b0, 16'h0200, 16'h0, 1'b0, 1'b0, 2));
        drain(100);
        cq[1].push_back(mk(1'b1, 16'hFE00, 16'h4000, 1'b0, 1'b0, -1));
        drain(100);
        cq[0].push_back(mk(1'b0, 16'hFE00, 16'h0, 1'b0, 1'b0, -1));
        drain(100);
        cq[1].push_back(mk(1'b1, 16'h0300, 16'h1234, 1'b1, 1'b1, -1));
        drain(100);
        cq[0].push_back(mk(1'b0, 16'h0300, 16'h0, 1'b0, 1'b0, -1));
        drain(100);

        // write abandoned by reset in SERVE
        t = mk(1'b1, 16'h0700, 16'hBEEF, 1'b0, 1'b0, -1);
        t.noexp = 1'b1;
        cq[1].push_back(t);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = ram_we;
        end
        if (!seen) tmo = 1'b1;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;

        // contention, both ports held continuously
        for (int i = 0; i < 4; i++) begin
            cq[0].push_back(mk(1'b0, pool[i], 16'h0, 1'b0, 1'b0, -1));
            cq[1].push_back(mk(1'b0, pool[i+1], 16'h0, 1'b0, 1'b0, -1));
        end
        mode = 1;
        drain(200);
        mode = 0;
        step();

        mode = 2;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 60; i++)
                cq[p].push_back(mk(1'($urandom),
                                   pool[$urandom_range(0, 5)],
                                   16'($urandom),
                                   $urandom_range(0, 3) == 0,
                                   1'($urandom), -1));
        drain(3000);
        mode = 0;
        done = 1'b1;
        repeat (20) step();
        $display("FAIL watchdog: monitor did not finish");
        $fatal(1);
    end

    // ---------------- monitor / scoreboard ----------------
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] last_rd;
    logic        pw_we;
    logic [15:0] pw_a, pw_d;
    logic        prev_rst;
    bit          have_last;
    int          last_p, last_c;
    int          f_n0, f_n1;

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        txn_t        e;
        logic [15:0] x;
        ncmp = 0; nerr = 0; last_rd = '0;
        pw_we = 1'b0; pw_a = '0; pw_d = '0; prev_rst = 1'b0;
        have_last = 1'b0; last_p = 0; last_c = 0; f_n0 = 0; f_n1 = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk({ram_we, ack, busy, gnt_id, rdata, ram_a, ram_d} ==
                    {4'b0, 1'b1, 48'h0}, "reset_state",
                    {ram_we, ack, busy, gnt_id, rdata, ram_a, ram_d},
                    {4'b0, 1'b1, 48'h0});
                last_rd = '0;
            end else begin
                if (!prev_rst)
                    chk(ram[16'h0700] == ref_rd(16'h0700), "ram_0700_kept",
                        ram[16'h0700], ref_rd(16'h0700));
                if (ram_we)
                    chk(busy && ack == 2'b00 && !pw_we, "ram_we_pulse",
                        {busy, ack, pw_we}, 4'b1000);
                if (ack == 2'b11)
                    chk(1'b0, "dual_ack", ack, 2'b01);
                for (int p = 0; p < 2; p++) begin
                    if (ack[p]) begin
                        if (eq[p].size() == 0) begin
                            chk(1'b0, "unexpected_ack", p, 0);
                        end else begin
                            e = eq[p].pop_front();
                            chk(gnt_id == 1'(p), "ack_gnt_id", gnt_id, p);
                            if (e.lat >= 0)
                                chk(cyc - e.t0 == e.lat, "ack_latency",
                                    cyc - e.t0, e.lat);
                            if (e.we) begin
                                chk(pw_we && pw_a == e.addr &&
                                    pw_d == e.wdata &&
                                    ram[e.addr] == e.wdata, "write_commit",
                                    {pw_we, pw_a, pw_d, ram[e.addr]},
                                    {1'b1, e.addr, e.wdata, e.wdata});
                                chk(rdata == last_rd, "rdata_hold",
                                    rdata, last_rd);
                                ref_mem[e.addr] = e.wdata;
                            end else begin
                                x = ref_rd(e.addr);
                                chk(!pw_we && rdata == x, "read_data",
                                    {pw_we, rdata}, {1'b0, x});
                                last_rd = x;
                            end
                            if (mode == 1) begin
                                if (have_last) begin
                                    chk(p != last_p, "rr_alternate",
                                        p, 1 - last_p);
                                    chk(cyc - last_c == 3, "ack_spacing",
                                        cyc - last_c, 3);
                                end else begin
                                    chk(p == 0, "rr_first_port0", p, 0);
                                end
                                have_last = 1'b1;
                                last_p = p;
                                last_c = cyc;
                            end
                        end
                    end
                end
                if (f_ack0) begin
                    f_n0++;
                    chk(f_rdata == init_val(16'h0010), "fp_rdata",
                        f_rdata, init_val(16'h0010));
                end
                if (f_ack1) f_n1++;
            end
            if (mode != 1) have_last = 1'b0;
            pw_we = ram_we; pw_a = ram_a; pw_d = ram_d;
            prev_rst = rst_n;
            if (done) begin
                chk(eq[0].size() == 0 && eq[1].size() == 0, "scoreboard_empty",
                    eq[0].size() + eq[1].size(), 0);
                chk(!tmo, "no_timeout", tmo, 0);
                chk(f_n1 == 0, "fp_port1_never_acked", f_n1, 0);
                chk(f_n0 >= 4, "fp_port0_served", f_n0, 4);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                         ncmp, nerr);
                $finish;
            end
        end
    end

endmodule
